cache_store: RTL and testbench
==============================

// Module: cache_store
// PURPOSE
//  Direct-mapped data cache array with tag/valid store, combinational hit detection and a block refill engine.
//  Sits directly downstream of the cache controller: consumes address/read/write and returns HMbar.
//  On a controller write pulse it refills the addressed 4-word block from main memory through a ready handshake.
//  Keeps saturating access and hit counters for hit-rate measurement.
// PARAMETERS
//  ADDR_W    15  word address width (tag 5 | index 8 | offset 2)
//  DATA_W    32  word width
//  INDEX_W   8   cache lines; 256 blocks x 4 words = 1K words
//  CNT_W     16  width of access/hit counters
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  address    in   15      word address from controller
//  read       in   1       lookup strobe; counted once per cycle it is high
//  write      in   1       refill request for block containing address
//  HMbar      out  1       1 = hit, 0 = miss (combinational from address)
//  data_out   out  32      addressed word (valid only when HMbar=1)
//  mem_addr   out  15      word address to main memory
//  mem_rd     out  1       memory read request
//  mem_rdy    in   1       memory has mem_rdata valid this cycle
//  mem_rdata  in   32      memory read data
//  fill_busy  out  1       refill in progress
//  fill_done  out  1       one-cycle pulse after last word stored
//  overrun    out  1       sticky: write arrived while fill_busy
//  access_cnt out  16      cycles with read=1, saturating at 16'hFFFF
//  hit_cnt    out  16      cycles with read=1 and HMbar=1, saturating
// BEHAVIOUR
//  - Reset: valid[] all 0, state IDLE, mem_rd=0, mem_addr=0, fill_busy=0, fill_done=0, overrun=0, counters 0.
//    Tag/data arrays not reset. Reset mid-refill aborts; the line being filled stays invalid.
//  - Lookup (0 latency): HMbar = valid[idx] & (tag[idx]==addr[14:10]) & ~(fill_busy & fill_idx==idx).
//    data_out = data[idx][addr[1:0]] regardless of HMbar.
//  - Counters: on posedge with read=1: access_cnt+1; hit_cnt+1 if HMbar. Each holds at 16'hFFFF.
//  - FSM states IDLE, FETCH:
//    IDLE: write=1 -> latch base={addr[14:2],2'b00}, fill_idx, fill_tag; clear valid[idx]; cnt=0;
//          mem_rd=1, mem_addr=base; go FETCH (fill_busy=1 next cycle).
//    FETCH: mem_rd and mem_addr held stable until mem_rdy sampled high. On mem_rdy: data[fill_idx][cnt]<=mem_rdata;
//          if cnt<3: cnt+1, mem_addr=base+cnt+1; if cnt==3: tag<=fill_tag, valid<=1, mem_rd=0,
//          fill_done=1 for one cycle, go IDLE.
//  - Minimum refill latency 4 cycles (mem_rdy tied high); block becomes hittable the cycle after fill_done rises.
//  - write during FETCH (incl. cycle of completion): ignored, overrun<=1 (sticky until rst).
//  - read and write same cycle in IDLE: lookup/counting use pre-refill contents; refill starts.
//  - mem_rdy while mem_rd=0 is ignored. Offset bits of address ignored for refill.
//  - Offset wrap: mem_addr never crosses block; base+3 is last word.
// STRUCTURE
//  - Shared package cache_pkg: ADDR_W, DATA_W, TAG_W=5, INDEX_W=8, OFFSET_W=2, field-slice macros/functions,
//    refill state encoding (IDLE=1'b0, FETCH=1'b1).
//  - One sub-module: cache_refill_fsm (state, cnt, base, mem handshake, fill_done/overrun); arrays,
//    lookup and counters stay in cache_store.
// TESTING
//  - Reset, read addr 15'h0123 -> HMbar=0, access_cnt=1, hit_cnt=0; no mem_rd.
//  - write addr 15'h0125, mem_rdy=1, mem_rdata=32'hA0+offset -> mem_addr 0124..0127 over 4 cycles, fill_done
//    pulses once; then read 15'h0126 -> HMbar=1, data_out=32'hA2.
//  - Conflict: fill 15'h0124, then fill 15'h0524 (same index, tag 1) -> read 15'h0124 misses, 15'h0524 hits.
//  - mem_rdy stalled 3 cycles per word -> mem_addr/mem_rd stable while stalled; lookup of fill index
//    reports HMbar=0 throughout; total refill 16 cycles.
//  - write mid-FETCH -> overrun=1, ongoing fill unaffected; rst mid-FETCH -> mem_rd=0, line invalid, overrun=0.
//  - Force access_cnt/hit_cnt to 16'hFFFE, two hitting reads -> both counters hold 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_pkg
// Brief  : Shared widths, address field helpers and refill state encoding
//          for the direct-mapped cache store.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 5;
  localparam int INDEX_W   = 8;
  localparam int OFFSET_W  = 2;
  localparam int CNT_W     = 16;
  localparam int BLK_W     = TAG_W + INDEX_W;
  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int NUM_WORDS = 2 ** (INDEX_W + OFFSET_W);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fill_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  // Block address: tag and index together, offset dropped
  function automatic logic [BLK_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_store_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_store_if
// Brief  : Controller lookup/refill signals plus main-memory handshake and
//          status counters of the cache store.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface cache_store_if;
  import cache_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              HMbar;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_busy;
  logic              fill_done;
  logic              overrun;
  logic [CNT_W-1:0]  access_cnt;
  logic [CNT_W-1:0]  hit_cnt;

  // Controller plus memory side
  modport master (
    output address, read, write, mem_rdy, mem_rdata,
    input  HMbar, data_out, mem_addr, mem_rd, fill_busy, fill_done, overrun,
           access_cnt, hit_cnt
  );

  // Cache store side
  modport slave (
    input  address, read, write, mem_rdy, mem_rdata,
    output HMbar, data_out, mem_addr, mem_rd, fill_busy, fill_done, overrun,
           access_cnt, hit_cnt
  );

endinterface
`default_nettype wire

// File: rtl/cache_refill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_refill_fsm
// Brief  : Block refill engine: latches the block address on a write,
//          walks the four words through the memory ready handshake and
//          tells the array when to invalidate, store and commit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module cache_refill_fsm
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                write_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                mem_rdy_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_rd_o,
  output logic                fill_busy_o,
  output logic                fill_done_o,
  output logic                overrun_o,
  output logic                start_o,     // refill accepted: invalidate addressed line
  output logic                wr_en_o,     // store mem_rdata at fill_idx/fill_off
  output logic                commit_o,    // last word: install tag, set valid
  output logic [INDEX_W-1:0]  fill_idx_o,
  output logic [OFFSET_W-1:0] fill_off_o,
  output logic [TAG_W-1:0]    fill_tag_o
);

  fill_state_e         state_q, state_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  // State and datapath registers; reset aborts any refill in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and array strobes; word counter stops at the last word so the
  // memory address never leaves the block
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    start_o  = 1'b0;
    wr_en_o  = 1'b0;
    commit_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          blk_d   = addr_blk(addr_i);
          cnt_d   = '0;
          start_o = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (write_i) begin
          ovr_d = 1'b1;
        end
        if (mem_rdy_i) begin
          wr_en_o = 1'b1;
          if (cnt_q == '1) begin
            commit_o = 1'b1;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o  = {blk_q, cnt_q};
  assign mem_rd_o    = (state_q == FETCH);
  assign fill_busy_o = (state_q == FETCH);
  assign fill_done_o = done_q;
  assign overrun_o   = ovr_q;
  assign fill_idx_o  = blk_q[INDEX_W-1:0];
  assign fill_tag_o  = blk_q[BLK_W-1 -: TAG_W];
  assign fill_off_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cache_store.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_store
// Brief  : Direct-mapped data/tag/valid arrays with zero-latency hit
//          detection, block refill and saturating access/hit counters.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module cache_store
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cache_store_if.slave bus
);

  logic [INDEX_W-1:0]  lu_idx;
  logic [TAG_W-1:0]    lu_tag;
  logic [OFFSET_W-1:0] lu_off;
  logic                hit;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_WORDS];

  logic [CNT_W-1:0]     access_q, access_d;
  logic [CNT_W-1:0]     hits_q, hits_d;

  logic                 fill_start;
  logic                 fill_wr;
  logic                 fill_commit;
  logic                 fill_busy;
  logic [INDEX_W-1:0]   fill_idx;
  logic [OFFSET_W-1:0]  fill_off;
  logic [TAG_W-1:0]     fill_tag;

  cache_refill_fsm u_refill (
    .clk         (clk),
    .rst         (rst),
    .write_i     (bus.write),
    .addr_i      (bus.address),
    .mem_rdy_i   (bus.mem_rdy),
    .mem_addr_o  (bus.mem_addr),
    .mem_rd_o    (bus.mem_rd),
    .fill_busy_o (fill_busy),
    .fill_done_o (bus.fill_done),
    .overrun_o   (bus.overrun),
    .start_o     (fill_start),
    .wr_en_o     (fill_wr),
    .commit_o    (fill_commit),
    .fill_idx_o  (fill_idx),
    .fill_off_o  (fill_off),
    .fill_tag_o  (fill_tag)
  );

  assign lu_idx = addr_idx(bus.address);
  assign lu_tag = addr_tag(bus.address);
  assign lu_off = addr_off(bus.address);

  // The line under refill never hits, even before its valid bit is observed
  assign hit = valid_q[lu_idx] & (tag_q[lu_idx] == lu_tag)
             & ~(fill_busy & (fill_idx == lu_idx));

  assign bus.HMbar      = hit;
  assign bus.data_out   = data_q[{lu_idx, lu_off}];
  assign bus.fill_busy  = fill_busy;
  assign bus.access_cnt = access_q;
  assign bus.hit_cnt    = hits_q;

  // Valid bits: cleared when a refill starts, set when its last word lands
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (fill_start) begin
        valid_q[lu_idx] <= 1'b0;
      end
      if (fill_commit) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_q[{fill_idx, fill_off}] <= bus.mem_rdata;
    end
    if (fill_commit) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

  // Saturating counters; a lookup is judged against pre-refill contents
  always_comb begin
    access_d = access_q;
    hits_d   = hits_q;
    if (bus.read) begin
      if (access_q != '1) begin
        access_d = access_q + 1'b1;
      end
      if (hit && (hits_q != '1)) begin
        hits_d = hits_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      access_q <= '0;
      hits_q   <= '0;
    end else begin
      access_q <= access_d;
      hits_q   <= hits_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_store.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_cache_store
// Brief  : Directed, table-driven bench for cache_store with hand sequences
//          for stalled refill, overrun, reset abort and counter saturation.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_cache_store;

  logic        clk;
  logic        rst;
  logic [31:0] mem_base;
  int          checks;
  int          failures;

  cache_store_if bus ();

  cache_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: each word returns base plus its offset within the block
  assign bus.mem_rdata = mem_base + {30'd0, bus.mem_addr[1:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic        rd;
    logic        wr;
    logic        rdy;
    logic [31:0] mbase;
    logic        hm;
    logic        chk_data;
    logic [31:0] data;
    logic        mrd;
    logic [14:0] maddr;
    logic        busy;
    logic        done;
    logic        ovr;
    logic [15:0] acc;
    logic [15:0] hit;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [14:0] a, input logic rd, input logic wr, input logic rdy);
    bus.address = a;
    bus.read    = rd;
    bus.write   = wr;
    bus.mem_rdy = rdy;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    int done_pulses;
    logic [14:0] a;

    checks   = 0;
    failures = 0;
    mem_base = 32'hA0;
    rst      = 1'b1;
    set_in(15'h0, 1'b0, 1'b0, 1'b0);

    //            addr     rd    wr    rdy   mbase     hm    cd    data      mrd   maddr    bsy   dn    ov    acc     hit
    vt[0]  = '{15'h0123, 1'b1, 1'b0, 1'b0, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vt[1]  = '{15'h0123, 1'b0, 1'b0, 1'b0, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[2]  = '{15'h0125, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[3]  = '{15'h0126, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0124, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[4]  = '{15'h0126, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0125, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[5]  = '{15'h0126, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0126, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[6]  = '{15'h0126, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0127, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[7]  = '{15'h0126, 1'b1, 1'b0, 1'b0, 32'hA0, 1'b1, 1'b1, 32'hA2, 1'b0, 15'h0127, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
    vt[8]  = '{15'h0124, 1'b1, 1'b0, 1'b0, 32'hA0, 1'b1, 1'b1, 32'hA0, 1'b0, 15'h0127, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[9]  = '{15'h0127, 1'b0, 1'b0, 1'b0, 32'hA0, 1'b1, 1'b1, 32'hA3, 1'b0, 15'h0127, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2};
    vt[10] = '{15'h0524, 1'b1, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b0, 15'h0127, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2};
    vt[11] = '{15'h0524, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0524, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2};
    vt[12] = '{15'h0524, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0525, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2};
    vt[13] = '{15'h0524, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0526, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2};
    vt[14] = '{15'h0524, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b1, 15'h0527, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2};
    vt[15] = '{15'h0124, 1'b1, 1'b0, 1'b0, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b0, 15'h0527, 1'b0, 1'b1, 1'b0, 16'd4, 16'd2};
    vt[16] = '{15'h0526, 1'b1, 1'b0, 1'b0, 32'hB0, 1'b1, 1'b1, 32'hB2, 1'b0, 15'h0527, 1'b0, 1'b0, 1'b0, 16'd5, 16'd2};
    vt[17] = '{15'h0123, 1'b0, 1'b0, 1'b0, 32'hB0, 1'b0, 1'b0, 32'h0,  1'b0, 15'h0527, 1'b0, 1'b0, 1'b0, 16'd6, 16'd3};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, first miss, basic refill, hit, conflict refill
    for (int i = 0; i < 18; i++) begin
      set_in(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].rdy);
      mem_base = vt[i].mbase;
      #1;
      chk($sformatf("v%0d.HMbar", i),      32'(bus.HMbar),      32'(vt[i].hm));
      if (vt[i].chk_data)
        chk($sformatf("v%0d.data_out", i), bus.data_out,        vt[i].data);
      chk($sformatf("v%0d.mem_rd", i),     32'(bus.mem_rd),     32'(vt[i].mrd));
      chk($sformatf("v%0d.mem_addr", i),   32'(bus.mem_addr),   32'(vt[i].maddr));
      chk($sformatf("v%0d.fill_busy", i),  32'(bus.fill_busy),  32'(vt[i].busy));
      chk($sformatf("v%0d.fill_done", i),  32'(bus.fill_done),  32'(vt[i].done));
      chk($sformatf("v%0d.overrun", i),    32'(bus.overrun),    32'(vt[i].ovr));
      chk($sformatf("v%0d.access_cnt", i), 32'(bus.access_cnt), 32'(vt[i].acc));
      chk($sformatf("v%0d.hit_cnt", i),    32'(bus.hit_cnt),    32'(vt[i].hit));
      tick();
    end

    // mem_rdy with no request outstanding must not start anything
    set_in(15'h2A10, 1'b0, 1'b0, 1'b1);
    mem_base = 32'hC0;
    #1;
    chk("idle_rdy.mem_rd", 32'(bus.mem_rd), 32'd0);
    tick();
    chk("idle_rdy.fill_busy", 32'(bus.fill_busy), 32'd0);

    // Stalled refill: three wait cycles before every word
    set_in(15'h2A10, 1'b0, 1'b1, 1'b0);
    tick();
    busy_cycles = 0;
    done_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      a = 15'h2A10 + 15'((c < 16) ? c / 4 : 3);
      set_in(a, 1'b0, 1'b0, (c % 4) == 3);
      #1;
      if (bus.fill_busy) busy_cycles++;
      if (bus.fill_done) done_pulses++;
      if (c < 16) begin
        chk($sformatf("stall%0d.mem_rd", c),   32'(bus.mem_rd),   32'd1);
        chk($sformatf("stall%0d.mem_addr", c), 32'(bus.mem_addr), 32'(a));
        chk($sformatf("stall%0d.HMbar", c),    32'(bus.HMbar),    32'd0);
      end
      if (c == 16)
        chk("stall.fill_done", 32'(bus.fill_done), 32'd1);
      tick();
    end
    chk("stall.busy_cycles", 32'(busy_cycles), 32'd16);
    chk("stall.done_pulses", 32'(done_pulses), 32'd1);
    set_in(15'h2A12, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall.HMbar", 32'(bus.HMbar), 32'd1);
    chk("stall.data_out", bus.data_out, 32'hC2);
    tick();

    // Overrun: writes mid-fill and on the completion cycle are ignored
    mem_base = 32'hD0;
    set_in(15'h0300, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(15'h0300, 1'b0, 1'b0, 1'b1);
    #1;
    chk("ovr.c1.mem_addr", 32'(bus.mem_addr), 32'h0300);
    chk("ovr.c1.overrun",  32'(bus.overrun),  32'd0);
    tick();
    set_in(15'h7FFC, 1'b0, 1'b1, 1'b1);
    #1;
    chk("ovr.c2.mem_addr", 32'(bus.mem_addr), 32'h0301);
    tick();
    set_in(15'h7FFC, 1'b0, 1'b0, 1'b1);
    #1;
    chk("ovr.c3.mem_addr", 32'(bus.mem_addr), 32'h0302);
    chk("ovr.c3.overrun",  32'(bus.overrun),  32'd1);
    tick();
    set_in(15'h7FFC, 1'b0, 1'b1, 1'b1);
    #1;
    chk("ovr.c4.mem_addr", 32'(bus.mem_addr), 32'h0303);
    tick();
    set_in(15'h0301, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovr.fill_done", 32'(bus.fill_done), 32'd1);
    chk("ovr.fill_busy", 32'(bus.fill_busy), 32'd0);
    chk("ovr.overrun",   32'(bus.overrun),   32'd1);
    chk("ovr.HMbar",     32'(bus.HMbar),     32'd1);
    chk("ovr.data_out",  bus.data_out,       32'hD1);
    bus.address = 15'h7FFC;
    #1;
    chk("ovr.ignored_line", 32'(bus.HMbar), 32'd0);
    tick();

    // Reset in the middle of a refill
    set_in(15'h0400, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(15'h0400, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rstmid.mem_rd_before", 32'(bus.mem_rd), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid.mem_rd",     32'(bus.mem_rd),     32'd0);
    chk("rstmid.fill_busy",  32'(bus.fill_busy),  32'd0);
    chk("rstmid.overrun",    32'(bus.overrun),    32'd0);
    chk("rstmid.mem_addr",   32'(bus.mem_addr),   32'h0);
    chk("rstmid.access_cnt", 32'(bus.access_cnt), 32'd0);
    chk("rstmid.HMbar",      32'(bus.HMbar),      32'd0);
    bus.address = 15'h0301;
    #1;
    chk("rstmid.old_line",   32'(bus.HMbar),      32'd0);
    tick();

    // Counter saturation on a hitting address
    mem_base = 32'hE0;
    set_in(15'h0010, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(15'h0011, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    chk("sat.start_acc", 32'(bus.access_cnt), 32'd0);
    chk("sat.HMbar",     32'(bus.HMbar),      32'd1);
    chk("sat.data_out",  bus.data_out,        32'hE1);
    bus.read = 1'b1;
    repeat (65534) tick();
    chk("sat.acc_fffe", 32'(bus.access_cnt), 32'hFFFE);
    chk("sat.hit_fffe", 32'(bus.hit_cnt),    32'hFFFE);
    repeat (2) tick();
    bus.read = 1'b0;
    #1;
    chk("sat.acc_ffff", 32'(bus.access_cnt), 32'hFFFF);
    chk("sat.hit_ffff", 32'(bus.hit_cnt),    32'hFFFF);
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    #1;
    chk("sat.acc_hold", 32'(bus.access_cnt), 32'hFFFF);
    chk("sat.hit_hold", 32'(bus.hit_cnt),    32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
